lsu: RTL and testbench
======================

# lsu

Parametrised load/store unit between the MEM pipeline stage and the data-memory bus. It accepts one load or store request at a time and generates byte enables and lane-shifted write data. It issues one or two bus beats, with two beats only for a misaligned access that crosses a word boundary and only when splitting is enabled. Load data is realigned and sign- or zero-extended to the requested size. It generalises the combinational load-extension logic with data width, doubleword support, misalignment handling, exceptions and a bus handshake.

## Interface
- DATA_W, 32: bus and register data width; 32 or 64.
- ADDR_W, 32: byte address width.
- SPLIT_MISALIGNED, 0: 1 = split boundary-crossing accesses into two beats; 0 = raise exception instead.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (legal only when DATA_W=64).
- req_unsigned  in  1  zero-extend load (lbu/lhu/lwu).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- bus_valid  out  1  bus beat valid.
- bus_ready  in  1  bus accepts beat.
- bus_we  out  1  beat is a write.
- bus_addr  out  ADDR_W  lane-aligned address; low log2(DATA_W/8) bits are 0.
- bus_be  out  DATA_W/8  byte enables.
- bus_wdata  out  DATA_W  lane-positioned write data.
- bus_rvalid  in  1  read data returned for the oldest accepted read beat.
- bus_rdata  in  DATA_W  read data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  extended load result; 0 for stores and exceptions.
- rsp_exc  out  1  with rsp_valid: misaligned access (SPLIT_MISALIGNED=0) or illegal size.

## Operation
- Definitions: L = DATA_W/8 lanes; off = req_addr mod L; n = 2^req_size bytes.
- An access is misaligned when addr mod n ≠ 0. It crosses when off + n > L.
- Illegal requests raise an exception: req_size=3 with DATA_W=32, or misaligned with SPLIT_MISALIGNED=0. The response is rsp_exc=1 with no bus traffic.
- FSM states:
  - IDLE: req_ready=1; on accept, latch the request and go to EXC if illegal, else B1.
  - B1: bus_valid=1, bus_addr = addr with the low bits cleared, bus_be = (n-bit mask << off) truncated to L.
  - B1 on handshake: load → W1; store → B2 if crossing, else RSP.
  - W1: await bus_rvalid; capture the enabled lanes; go to B2 if crossing, else RSP.
  - B2: bus_addr = beat-1 address + L, bus_be = mask >> (L - off). On handshake: load → W2, store → RSP.
  - W2: await bus_rvalid, capture lanes, → RSP.
  - RSP and EXC: rsp_valid=1 for one cycle, then → IDLE.
- Store data: bus_wdata = req_wdata rotated left by 8·off bits, identical on both beats.
- Load assembly: bytes are gathered in address order (beat-1 lanes off..L-1, then beat-2 lanes 0..), truncated to n bytes, then extended. Sign extension copies bit 8n-1 unless req_unsigned.
- Bus outputs stay stable while bus_valid=1 and bus_ready=0.
- bus_rvalid outside W1/W2 is ignored.

## Timing
- Reset (asynchronous assert): state=IDLE; req_ready=1; all other outputs 0, including bus_valid, rsp_valid and rsp_rdata.
- A request is accepted at edge T (req_valid & req_ready). bus_valid rises at T+1.
- Aligned load, best case: bus_ready at T+1, rvalid at T+2, rsp_valid at T+3.
- Aligned store, best case: rsp_valid at T+2.
- Exception response: rsp_valid at T+1.
- Each crossing access adds 2 cycles for a load and 1 cycle for a store, plus any bus stall cycles.
- Reset mid-access abandons the access with no rsp_valid. A late bus_rvalid after reset is ignored.
- req_ready=0 in every state except IDLE. There is no request pipelining.

## Structure
- lsu_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - the state enum;
  - functions size_mask(size) and extend(data, size, unsigned).
- Sub-module lsu_lane_align is purely combinational. It computes the mask, rotates store data, and assembles and extends load data from the two captured beats.
- The FSM, request latches and beat capture registers stay in lsu.

## Test plan
- DATA_W=32, LB at 0x1003 with rdata 0x80FF1234 → rsp_rdata 0xFFFFFF80. Same access as LBU → 0x00000080. bus_be=1000 in both cases.
- LH at 0x1002 with rdata 0x80017FFF → 0xFFFF8001, bus_be=1100.
- SH at 0x1001 (odd, within word), SPLIT=1, wdata 0x0000ABCD → a single beat with be=0110 and bus_wdata 0x00ABCD00. With SPLIT=0 → rsp_exc=1 at T+1 and no bus_valid.
- LW at 0x1002, SPLIT=1:
  - beat 1: addr 0x1000, be=1100, rdata 0x44332211;
  - beat 2: addr 0x1004, be=0011, rdata 0x88776655;
  - result: rsp_rdata 0x66554433.
- bus_ready held low for 3 cycles during SW 0x1000 → bus_addr, bus_be and bus_wdata stable throughout; rsp_valid exactly once after the handshake.
- Reset asserted in W1, then bus_rvalid pulses → no rsp_valid, state IDLE, all outputs at reset values. DATA_W=32 with req_size=3 → rsp_exc=1.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module : lsu_pkg
// Purpose: Shared definitions for the load/store unit: access-size codes,
//          FSM state encoding, and helpers for the lane mask and load
//          extension.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_B1   = 3'd1,
        ST_W1   = 3'd2,
        ST_B2   = 3'd3,
        ST_W2   = 3'd4,
        ST_RSP  = 3'd5,
        ST_EXC  = 3'd6
    } state_t;

    // Byte mask covering 2^size bytes, right-justified.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Sign- or zero-extend the low 2^size bytes of data to 64 bits.
    function automatic logic [63:0] extend(input logic [63:0] data,
                                           input logic [1:0]  size,
                                           input logic        is_unsigned);
        case (size)
            SZ_B:    return {{56{~is_unsigned & data[7]}},  data[7:0]};
            SZ_H:    return {{48{~is_unsigned & data[15]}}, data[15:0]};
            SZ_W:    return {{32{~is_unsigned & data[31]}}, data[31:0]};
            default: return data;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module : lsu_lane_align
// Purpose: Combinational lane steering for the LSU.
//   size/off/is_unsigned : latched access size, byte offset within the word,
//                          and zero-extend flag
//   wdata                : right-justified store data
//   beat1/beat2          : captured read data of the first and second beat
//   be1/be2              : byte enables for the first and second beat
//   wdata_rot            : store data rotated into its byte lanes
//   load_data            : realigned and extended load result
// Rev    : 1.0  initial release
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]                   size,
    input  logic [$clog2(DATA_W/8)-1:0]  off,
    input  logic                         is_unsigned,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [DATA_W-1:0]            beat1,
    input  logic [DATA_W-1:0]            beat2,
    output logic [DATA_W/8-1:0]          be1,
    output logic [DATA_W/8-1:0]          be2,
    output logic [DATA_W-1:0]            wdata_rot,
    output logic [DATA_W-1:0]            load_data
);
    localparam int L = DATA_W / 8;

    logic [L-1:0]   mask;
    logic [2*L-1:0] be_wide;

    always_comb begin
        mask    = L'(size_mask(size));
        // Lower half is the first beat's enables, upper half spills into
        // the next word, i.e. mask >> (L - off).
        be_wide = {{L{1'b0}}, mask} << off;
        be1     = L'(be_wide);
        be2     = L'(be_wide >> L);
        // Upper half of {x,x} << k is x rotated left by k.
        wdata_rot = DATA_W'(({wdata, wdata} << {off, 3'b000}) >> DATA_W);
        // Bytes in address order: beat-1 lanes off..L-1, then beat-2 lanes.
        load_data = DATA_W'(extend(64'(DATA_W'({beat2, beat1} >> {off, 3'b000})),
                                   size, is_unsigned));
    end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module : lsu
// Purpose: Load/store unit between the MEM stage and the data-memory bus.
//          Accepts one request at a time, issues one or two bus beats
//          (two only for boundary-crossing accesses when splitting is
//          enabled), and returns an extended load result or an exception.
//   clk, reset (async, active-low)
//   req_*  : request handshake and fields from the pipeline
//   bus_*  : beat handshake, lane-aligned address/enables/data, read return
//   rsp_*  : one-cycle completion pulse with load data and exception flag
// Rev    : 1.0  initial release
// ============================================================================
module lsu
    import lsu_pkg::*;
#(
    parameter int DATA_W           = 32,
    parameter int ADDR_W           = 32,
    parameter int SPLIT_MISALIGNED = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  bus_valid,
    input  logic                  bus_ready,
    output logic                  bus_we,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W/8-1:0]   bus_be,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_rvalid,
    input  logic [DATA_W-1:0]     bus_rdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_exc
);
    localparam int L    = DATA_W / 8;
    localparam int OFFW = $clog2(L);

    state_t              state, state_nxt;
    logic                lat_we, lat_unsigned;
    logic [1:0]          lat_size;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata, beat1, beat2;

    logic [2:0]          align_mask;
    logic                misaligned, illegal, crosses;
    logic [OFFW-1:0]     off;
    logic [4:0]          span;
    logic [ADDR_W-1:0]   base_addr;
    logic [L-1:0]        be1, be2;
    logic [DATA_W-1:0]   wdata_rot, load_data;

    // Legality is judged on the incoming request so EXC can be entered
    // straight from IDLE.
    always_comb begin
        case (req_size)
            SZ_B:    align_mask = 3'd0;
            SZ_H:    align_mask = 3'd1;
            SZ_W:    align_mask = 3'd3;
            default: align_mask = 3'd7;
        endcase
        misaligned = |(req_addr[2:0] & align_mask);
        illegal    = ((req_size == SZ_D) && (DATA_W != 64)) ||
                     (misaligned && (SPLIT_MISALIGNED == 0));
    end

    assign off       = lat_addr[OFFW-1:0];
    assign span      = 5'(off) + (5'd1 << lat_size);
    assign crosses   = span > 5'(L);
    assign base_addr = {lat_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};

    lsu_lane_align #(.DATA_W(DATA_W)) u_align (
        .size        (lat_size),
        .off         (off),
        .is_unsigned (lat_unsigned),
        .wdata       (lat_wdata),
        .beat1       (beat1),
        .beat2       (beat2),
        .be1         (be1),
        .be2         (be2),
        .wdata_rot   (wdata_rot),
        .load_data   (load_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_we       <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_size     <= '0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            beat1        <= '0;
            beat2        <= '0;
        end else begin
            if (state == ST_IDLE && req_valid) begin
                lat_we       <= req_we;
                lat_unsigned <= req_unsigned;
                lat_size     <= req_size;
                lat_addr     <= req_addr;
                lat_wdata    <= req_wdata;
                beat1        <= '0;
                beat2        <= '0;
            end
            if (state == ST_W1 && bus_rvalid) beat1 <= bus_rdata;
            if (state == ST_W2 && bus_rvalid) beat2 <= bus_rdata;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req_valid)  state_nxt = illegal ? ST_EXC : ST_B1;
            ST_B1:   if (bus_ready)  state_nxt = lat_we ? (crosses ? ST_B2 : ST_RSP) : ST_W1;
            ST_W1:   if (bus_rvalid) state_nxt = crosses ? ST_B2 : ST_RSP;
            ST_B2:   if (bus_ready)  state_nxt = lat_we ? ST_RSP : ST_W2;
            ST_W2:   if (bus_rvalid) state_nxt = ST_RSP;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bus outputs are pure functions of registered state, so they hold
    // steady while a beat is stalled.
    always_comb begin
        req_ready = (state == ST_IDLE);
        bus_valid = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_be    = '0;
        bus_wdata = '0;
        rsp_valid = 1'b0;
        rsp_exc   = 1'b0;
        rsp_rdata = '0;
        case (state)
            ST_B1: begin
                bus_valid = 1'b1;
                bus_we    = lat_we;
                bus_addr  = base_addr;
                bus_be    = be1;
                bus_wdata = lat_we ? wdata_rot : '0;
            end
            ST_B2: begin
                bus_valid = 1'b1;
                bus_we    = lat_we;
                bus_addr  = base_addr + ADDR_W'(L);
                bus_be    = be2;
                bus_wdata = lat_we ? wdata_rot : '0;
            end
            ST_RSP: begin
                rsp_valid = 1'b1;
                rsp_rdata = lat_we ? '0 : load_data;
            end
            ST_EXC: begin
                rsp_valid = 1'b1;
                rsp_exc   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module : tb_lsu
// Purpose: Directed self-checking bench for lsu with DATA_W=32. One instance
//          splits boundary-crossing accesses, the other raises exceptions.
// Rev    : 1.0  initial release
// ============================================================================
module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid_s, req_valid_n, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, bus_rdata;
    logic        bus_ready, bus_rvalid;

    logic        s_req_ready, s_bus_valid, s_bus_we, s_rsp_valid, s_rsp_exc;
    logic [31:0] s_bus_addr, s_bus_wdata, s_rsp_rdata;
    logic [3:0]  s_bus_be;
    logic        n_req_ready, n_bus_valid, n_bus_we, n_rsp_valid, n_rsp_exc;
    logic [31:0] n_bus_addr, n_bus_wdata, n_rsp_rdata;
    logic [3:0]  n_bus_be;

    int checks = 0;
    int errors = 0;

    lsu #(.DATA_W(32), .ADDR_W(32), .SPLIT_MISALIGNED(1)) dut_s (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_s), .req_ready(s_req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .bus_valid(s_bus_valid), .bus_ready(bus_ready), .bus_we(s_bus_we),
        .bus_addr(s_bus_addr), .bus_be(s_bus_be), .bus_wdata(s_bus_wdata),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .rsp_valid(s_rsp_valid), .rsp_rdata(s_rsp_rdata), .rsp_exc(s_rsp_exc)
    );

    lsu #(.DATA_W(32), .ADDR_W(32), .SPLIT_MISALIGNED(0)) dut_n (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_n), .req_ready(n_req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .bus_valid(n_bus_valid), .bus_ready(bus_ready), .bus_we(n_bus_we),
        .bus_addr(n_bus_addr), .bus_be(n_bus_be), .bus_wdata(n_bus_wdata),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .rsp_valid(n_rsp_valid), .rsp_rdata(n_rsp_rdata), .rsp_exc(n_rsp_exc)
    );

    // Presents one request for a single cycle; returns at the negedge after
    // the accepting edge.
    task automatic issue(input logic to_split, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_valid_s  = to_split;
        req_valid_n  = ~to_split;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(negedge clk);
        req_valid_s  = 1'b0;
        req_valid_n  = 1'b0;
    endtask

    task automatic test_reset;
        req_valid_s = 0; req_valid_n = 0; req_we = 0; req_size = 0; req_unsigned = 0;
        req_addr = 0; req_wdata = 0; bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({s_req_ready, s_bus_valid, s_bus_be, s_rsp_valid, s_rsp_exc, s_rsp_rdata} !== {1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_s: got ready=%b bv=%b be=%b rv=%b exc=%b rd=%h want 1 0 0000 0 0 0",
                     s_req_ready, s_bus_valid, s_bus_be, s_rsp_valid, s_rsp_exc, s_rsp_rdata);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({n_req_ready, n_bus_valid, n_rsp_valid, n_rsp_exc, n_bus_addr, n_bus_wdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_n: got ready=%b bv=%b rv=%b exc=%b addr=%h wd=%h want 1 0 0 0 0 0",
                     n_req_ready, n_bus_valid, n_rsp_valid, n_rsp_exc, n_bus_addr, n_bus_wdata);
        end
    endtask

    task automatic test_load_extend;
        logic [1:0]  sz [3] = '{SZ_B, SZ_B, SZ_H};
        logic        un [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] ad [3] = '{32'h1003, 32'h1003, 32'h1002};
        logic [31:0] rd [3] = '{32'h80FF1234, 32'h80FF1234, 32'h80017FFF};
        logic [31:0] ex [3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001};
        logic [3:0]  be [3] = '{4'b1000, 4'b1000, 4'b1100};
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, 1'b0, sz[i], un[i], ad[i], 32'h0);
            checks++;
            if ({s_bus_valid, s_bus_we, s_bus_addr, s_bus_be} !== {1'b1, 1'b0, 32'h1000, be[i]}) begin
                errors++;
                $display("FAIL load_beat[%0d]: got v=%b we=%b addr=%h be=%b want 1 0 00001000 %b",
                         i, s_bus_valid, s_bus_we, s_bus_addr, s_bus_be, be[i]);
            end
            bus_ready = 1'b1;
            @(negedge clk);
            bus_ready = 1'b0;
            bus_rvalid = 1'b1;
            bus_rdata = rd[i];
            @(negedge clk);
            bus_rvalid = 1'b0;
            checks++;
            if ({s_rsp_valid, s_rsp_exc, s_rsp_rdata} !== {1'b1, 1'b0, ex[i]}) begin
                errors++;
                $display("FAIL load_rsp[%0d]: got v=%b exc=%b data=%h want 1 0 %h",
                         i, s_rsp_valid, s_rsp_exc, s_rsp_rdata, ex[i]);
            end
            @(negedge clk);
            checks++;
            if ({s_rsp_valid, s_req_ready} !== 2'b01) begin
                errors++;
                $display("FAIL load_done[%0d]: got rv=%b ready=%b want 0 1", i, s_rsp_valid, s_req_ready);
            end
        end
    endtask

    task automatic test_store_in_word;
        issue(1'b1, 1'b1, SZ_H, 1'b0, 32'h1001, 32'h0000ABCD);
        checks++;
        if ({s_bus_valid, s_bus_we, s_bus_addr, s_bus_be, s_bus_wdata} !== {1'b1, 1'b1, 32'h1000, 4'b0110, 32'h00ABCD00}) begin
            errors++;
            $display("FAIL sh_beat: got v=%b we=%b addr=%h be=%b wd=%h want 1 1 00001000 0110 00abcd00",
                     s_bus_valid, s_bus_we, s_bus_addr, s_bus_be, s_bus_wdata);
        end
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        checks++;
        if ({s_rsp_valid, s_rsp_exc, s_rsp_rdata, s_bus_valid} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL sh_rsp: got rv=%b exc=%b rd=%h bv=%b want 1 0 0 0",
                     s_rsp_valid, s_rsp_exc, s_rsp_rdata, s_bus_valid);
        end
    endtask

    task automatic test_exception;
        logic        to_s [3] = '{1'b0, 1'b0, 1'b1};
        logic        we   [3] = '{1'b1, 1'b0, 1'b0};
        logic [1:0]  sz   [3] = '{SZ_H, SZ_W, SZ_D};
        logic [31:0] ad   [3] = '{32'h1001, 32'h1002, 32'h1000};
        logic        rv, ex, bv;
        logic [31:0] rd;
        for (int i = 0; i < 3; i++) begin
            issue(to_s[i], we[i], sz[i], 1'b0, ad[i], 32'h0000ABCD);
            rv = to_s[i] ? s_rsp_valid : n_rsp_valid;
            ex = to_s[i] ? s_rsp_exc   : n_rsp_exc;
            bv = to_s[i] ? s_bus_valid : n_bus_valid;
            rd = to_s[i] ? s_rsp_rdata : n_rsp_rdata;
            checks++;
            if ({rv, ex, bv, rd} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
                errors++;
                $display("FAIL exc_rsp[%0d]: got rv=%b exc=%b bv=%b rd=%h want 1 1 0 0", i, rv, ex, bv, rd);
            end
            @(negedge clk);
            rv = to_s[i] ? s_rsp_valid : n_rsp_valid;
            bv = to_s[i] ? s_bus_valid : n_bus_valid;
            checks++;
            if ({rv, bv, s_req_ready, n_req_ready} !== 4'b0011) begin
                errors++;
                $display("FAIL exc_done[%0d]: got rv=%b bv=%b rdy_s=%b rdy_n=%b want 0 0 1 1",
                         i, rv, bv, s_req_ready, n_req_ready);
            end
        end
    endtask

    task automatic test_cross_load;
        issue(1'b1, 1'b0, SZ_W, 1'b0, 32'h1002, 32'h0);
        checks++;
        if ({s_bus_valid, s_bus_addr, s_bus_be} !== {1'b1, 32'h1000, 4'b1100}) begin
            errors++;
            $display("FAIL lw_beat1: got v=%b addr=%h be=%b want 1 00001000 1100", s_bus_valid, s_bus_addr, s_bus_be);
        end
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata = 32'h44332211;
        @(negedge clk);
        bus_rvalid = 1'b0;
        checks++;
        if ({s_bus_valid, s_bus_addr, s_bus_be} !== {1'b1, 32'h1004, 4'b0011}) begin
            errors++;
            $display("FAIL lw_beat2: got v=%b addr=%h be=%b want 1 00001004 0011", s_bus_valid, s_bus_addr, s_bus_be);
        end
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata = 32'h88776655;
        @(negedge clk);
        bus_rvalid = 1'b0;
        checks++;
        if ({s_rsp_valid, s_rsp_exc, s_rsp_rdata} !== {1'b1, 1'b0, 32'h66554433}) begin
            errors++;
            $display("FAIL lw_cross_rsp: got v=%b exc=%b data=%h want 1 0 66554433", s_rsp_valid, s_rsp_exc, s_rsp_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_cross_store;
        issue(1'b1, 1'b1, SZ_W, 1'b0, 32'h1003, 32'h11223344);
        checks++;
        if ({s_bus_valid, s_bus_we, s_bus_addr, s_bus_be, s_bus_wdata} !== {1'b1, 1'b1, 32'h1000, 4'b1000, 32'h44112233}) begin
            errors++;
            $display("FAIL sw_beat1: got v=%b we=%b addr=%h be=%b wd=%h want 1 1 00001000 1000 44112233",
                     s_bus_valid, s_bus_we, s_bus_addr, s_bus_be, s_bus_wdata);
        end
        bus_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({s_bus_valid, s_bus_we, s_bus_addr, s_bus_be, s_bus_wdata} !== {1'b1, 1'b1, 32'h1004, 4'b0111, 32'h44112233}) begin
            errors++;
            $display("FAIL sw_beat2: got v=%b we=%b addr=%h be=%b wd=%h want 1 1 00001004 0111 44112233",
                     s_bus_valid, s_bus_we, s_bus_addr, s_bus_be, s_bus_wdata);
        end
        @(negedge clk);
        bus_ready = 1'b0;
        checks++;
        if ({s_rsp_valid, s_rsp_exc, s_rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL sw_cross_rsp: got v=%b exc=%b rd=%h want 1 0 0", s_rsp_valid, s_rsp_exc, s_rsp_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_back_pressure;
        int pulses = 0;
        issue(1'b1, 1'b1, SZ_W, 1'b0, 32'h1000, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({s_bus_valid, s_bus_addr, s_bus_be, s_bus_wdata, s_rsp_valid} !== {1'b1, 32'h1000, 4'b1111, 32'hDEADBEEF, 1'b0}) begin
                errors++;
                $display("FAIL stall[%0d]: got v=%b addr=%h be=%b wd=%h rv=%b want 1 00001000 1111 deadbeef 0",
                         i, s_bus_valid, s_bus_addr, s_bus_be, s_bus_wdata, s_rsp_valid);
            end
            if (i == 3) bus_ready = 1'b1;
            @(negedge clk);
        end
        bus_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (s_rsp_valid === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL stall_rsp_count: got %0d want 1", pulses);
        end
    endtask

    task automatic test_reset_mid_access;
        int pulses = 0;
        issue(1'b1, 1'b0, SZ_W, 1'b0, 32'h1000, 32'h0);
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        reset = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata = 32'hCAFEF00D;
        #1;
        checks++;
        if ({s_req_ready, s_bus_valid, s_bus_we, s_bus_addr, s_bus_be, s_bus_wdata, s_rsp_valid, s_rsp_exc, s_rsp_rdata}
            !== {1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL mid_reset_outs: got rdy=%b bv=%b we=%b addr=%h be=%b wd=%h rv=%b exc=%b rd=%h want 1 0 0 0 0 0 0 0 0",
                     s_req_ready, s_bus_valid, s_bus_we, s_bus_addr, s_bus_be, s_bus_wdata, s_rsp_valid, s_rsp_exc, s_rsp_rdata);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_rvalid = 1'b0;
            if (s_rsp_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || s_req_ready !== 1'b1 || s_bus_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_after: got pulses=%0d ready=%b bv=%b want 0 1 0", pulses, s_req_ready, s_bus_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_extend();
        test_store_in_word();
        test_exception();
        test_cross_load();
        test_cross_store();
        test_back_pressure();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
